// File: rtl/msrh_stq_commit_resp.sv
// Store-queue commit response pipeline: ST0 accept/L1D read, ST1 read check/LRQ, ST2 write result.
// Optional macro MSRH_STQ_COMMIT_HAZARD_EN: same-line requests stall at ST0 instead of replaying in ST1.
module msrh_stq_commit_resp #(
  parameter int unsigned STQ_SIZE   = 16,
  parameter int unsigned PADDR_W    = 56,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_OFS_W = 6,
  parameter int unsigned LRQ_SIZE   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,

  input  logic                        i_sq_req_valid,
  input  logic [$clog2(STQ_SIZE)-1:0] i_sq_req_index,
  input  logic [PADDR_W-1:0]          i_sq_req_paddr,
  input  logic [DATA_W-1:0]           i_sq_req_data,
  input  logic [DATA_W/8-1:0]         i_sq_req_be,

  output logic                        o_sq_op_accept,
  output logic [$clog2(STQ_SIZE)-1:0] o_sq_op_index,

  output logic [$clog2(STQ_SIZE)-1:0] o_sq_resp_index,
  output logic                        o_sq_l1d_rd_miss,
  output logic                        o_sq_l1d_rd_conflict,
  output logic                        o_sq_lrq_full,
  output logic                        o_sq_lrq_conflict,
  output logic [LRQ_SIZE-1:0]         o_sq_lrq_index_oh,

  output logic [$clog2(STQ_SIZE)-1:0] o_sq_wr_index,
  output logic                        o_sq_l1d_wr_conflict,

  output logic                        o_l1d_rd_valid,
  output logic [PADDR_W-1:0]          o_l1d_rd_paddr,
  input  logic                        i_l1d_rd_hit,
  input  logic                        i_l1d_rd_conflict,

  output logic                        o_lrq_req_valid,
  output logic [PADDR_W-1:0]          o_lrq_req_paddr,
  input  logic                        i_lrq_full,
  input  logic                        i_lrq_conflict,
  input  logic [LRQ_SIZE-1:0]         i_lrq_index_oh,

  output logic                        o_l1d_wr_valid,
  output logic [PADDR_W-1:0]          o_l1d_wr_paddr,
  output logic [DATA_W-1:0]           o_l1d_wr_data,
  output logic [DATA_W/8-1:0]         o_l1d_wr_be,
  input  logic                        i_l1d_wr_conflict
);

  localparam int unsigned IDX_W  = $clog2(STQ_SIZE);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LINE_W = PADDR_W - LINE_OFS_W;

  // Stage registers
  logic                r_st1_valid;
  logic [IDX_W-1:0]    r_st1_index;
  logic [PADDR_W-1:0]  r_st1_paddr;
  logic [DATA_W-1:0]   r_st1_data;
  logic [BE_W-1:0]     r_st1_be;

  logic                r_st2_valid;
  logic [IDX_W-1:0]    r_st2_index;
  logic [LINE_W-1:0]   r_st2_line;

  logic [LINE_W-1:0]   w_req_line;
  logic [LINE_W-1:0]   w_st1_line;
  logic                w_hazard;
  logic                w_st1_fwd_conflict;
  logic                w_accept;
  logic                w_st1_conflict;
  logic                w_st1_miss;
  logic                w_st1_hit;

  assign w_req_line = i_sq_req_paddr[PADDR_W-1:LINE_OFS_W];
  assign w_st1_line = r_st1_paddr[PADDR_W-1:LINE_OFS_W];

`ifdef MSRH_STQ_COMMIT_HAZARD_EN
  // Stall a request whose line is still being read or written downstream.
  logic w_st1_same;
  logic w_st2_same;
  assign w_st1_same         = r_st1_valid & (w_req_line == w_st1_line);
  assign w_st2_same         = r_st2_valid & (w_req_line == r_st2_line);
  assign w_hazard           = w_st1_same | w_st2_same;
  assign w_st1_fwd_conflict = 1'b0;
`else
  // No stall: a read racing an older same-line write in ST2 must be replayed.
  assign w_hazard           = 1'b0;
  assign w_st1_fwd_conflict = r_st1_valid & r_st2_valid & (w_st1_line == r_st2_line);
`endif

  // Reset gating keeps ST0 outputs quiet while i_reset_n is low.
  assign w_accept = i_reset_n & i_sq_req_valid & ~w_hazard;

  // ST1 outcome decode: conflict beats miss, miss beats hit.
  always_comb begin
    w_st1_conflict = 1'b0;
    w_st1_miss     = 1'b0;
    w_st1_hit      = 1'b0;
    if (r_st1_valid) begin
      if (i_l1d_rd_conflict || w_st1_fwd_conflict) begin
        w_st1_conflict = 1'b1;
      end else if (!i_l1d_rd_hit) begin
        w_st1_miss = 1'b1;
      end else begin
        w_st1_hit = 1'b1;
      end
    end
  end

  // ST0 -> ST1
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_st1_valid <= 1'b0;
      r_st1_index <= '0;
      r_st1_paddr <= '0;
      r_st1_data  <= '0;
      r_st1_be    <= '0;
    end else begin
      r_st1_valid <= w_accept;
      if (w_accept) begin
        r_st1_index <= i_sq_req_index;
        r_st1_paddr <= i_sq_req_paddr;
        r_st1_data  <= i_sq_req_data;
        r_st1_be    <= i_sq_req_be;
      end
    end
  end

  // ST1 -> ST2, only hits issue a write
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_st2_valid <= 1'b0;
      r_st2_index <= '0;
      r_st2_line  <= '0;
    end else begin
      r_st2_valid <= w_st1_hit;
      if (w_st1_hit) begin
        r_st2_index <= r_st1_index;
        r_st2_line  <= w_st1_line;
      end
    end
  end

  // ST0 outputs
  assign o_sq_op_accept = w_accept;
  assign o_sq_op_index  = w_accept ? i_sq_req_index : IDX_W'(0);
  assign o_l1d_rd_valid = w_accept;
  assign o_l1d_rd_paddr = w_accept ? i_sq_req_paddr : PADDR_W'(0);

  // ST1 outputs
  assign o_sq_resp_index      = r_st1_valid ? r_st1_index : IDX_W'(0);
  assign o_sq_l1d_rd_conflict = w_st1_conflict;
  assign o_sq_l1d_rd_miss     = w_st1_miss;
  assign o_lrq_req_valid      = w_st1_miss;
  assign o_lrq_req_paddr      = w_st1_miss ? r_st1_paddr : PADDR_W'(0);
  assign o_sq_lrq_full        = w_st1_miss & i_lrq_full;
  assign o_sq_lrq_conflict    = w_st1_miss & i_lrq_conflict;
  assign o_sq_lrq_index_oh    = (w_st1_miss & i_lrq_conflict & ~i_lrq_full) ?
                                i_lrq_index_oh : LRQ_SIZE'(0);
  assign o_l1d_wr_valid       = w_st1_hit;
  assign o_l1d_wr_paddr       = w_st1_hit ? r_st1_paddr : PADDR_W'(0);
  assign o_l1d_wr_data        = w_st1_hit ? r_st1_data : DATA_W'(0);
  assign o_l1d_wr_be          = w_st1_hit ? r_st1_be : BE_W'(0);

  // ST2 outputs
  assign o_sq_wr_index        = r_st2_valid ? r_st2_index : IDX_W'(0);
  assign o_sq_l1d_wr_conflict = r_st2_valid & i_l1d_wr_conflict;

endmodule

// File: tb/tb_msrh_stq_commit_resp.sv
// Directed bench for msrh_stq_commit_resp: vector table for single requests plus pipeline corner sequences.
module tb_msrh_stq_commit_resp;

  localparam int unsigned STQ_SIZE = 16;
  localparam int unsigned PADDR_W  = 56;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned LRQ_SIZE = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic [3:0]           req_index = '0;
  logic [PADDR_W-1:0]   req_paddr = '0;
  logic [DATA_W-1:0]    req_data = '0;
  logic [7:0]           req_be = '0;
  logic                 op_accept;
  logic [3:0]           op_index;
  logic [3:0]           resp_index;
  logic                 rd_miss, rd_conflict, lrq_full_o, lrq_conflict_o;
  logic [LRQ_SIZE-1:0]  lrq_index_oh_o;
  logic [3:0]           wr_index;
  logic                 wr_conflict_o;
  logic                 l1d_rd_valid;
  logic [PADDR_W-1:0]   l1d_rd_paddr;
  logic                 rd_hit = 1'b0, rd_conf_i = 1'b0;
  logic                 lrq_req_valid;
  logic [PADDR_W-1:0]   lrq_req_paddr;
  logic                 lrq_full_i = 1'b0, lrq_conf_i = 1'b0;
  logic [LRQ_SIZE-1:0]  lrq_oh_i = '0;
  logic                 l1d_wr_valid;
  logic [PADDR_W-1:0]   l1d_wr_paddr;
  logic [DATA_W-1:0]    l1d_wr_data;
  logic [7:0]           l1d_wr_be;
  logic                 wr_conf_i = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  msrh_stq_commit_resp #(
    .STQ_SIZE(STQ_SIZE), .PADDR_W(PADDR_W), .DATA_W(DATA_W), .LINE_OFS_W(6), .LRQ_SIZE(LRQ_SIZE)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_sq_req_valid(req_valid), .i_sq_req_index(req_index), .i_sq_req_paddr(req_paddr),
    .i_sq_req_data(req_data), .i_sq_req_be(req_be),
    .o_sq_op_accept(op_accept), .o_sq_op_index(op_index),
    .o_sq_resp_index(resp_index), .o_sq_l1d_rd_miss(rd_miss), .o_sq_l1d_rd_conflict(rd_conflict),
    .o_sq_lrq_full(lrq_full_o), .o_sq_lrq_conflict(lrq_conflict_o), .o_sq_lrq_index_oh(lrq_index_oh_o),
    .o_sq_wr_index(wr_index), .o_sq_l1d_wr_conflict(wr_conflict_o),
    .o_l1d_rd_valid(l1d_rd_valid), .o_l1d_rd_paddr(l1d_rd_paddr),
    .i_l1d_rd_hit(rd_hit), .i_l1d_rd_conflict(rd_conf_i),
    .o_lrq_req_valid(lrq_req_valid), .o_lrq_req_paddr(lrq_req_paddr),
    .i_lrq_full(lrq_full_i), .i_lrq_conflict(lrq_conf_i), .i_lrq_index_oh(lrq_oh_i),
    .o_l1d_wr_valid(l1d_wr_valid), .o_l1d_wr_paddr(l1d_wr_paddr), .o_l1d_wr_data(l1d_wr_data),
    .o_l1d_wr_be(l1d_wr_be), .i_l1d_wr_conflict(wr_conf_i)
  );

  typedef struct {
    logic [3:0]          idx;
    logic [PADDR_W-1:0]  paddr;
    logic                hit;
    logic                rd_conf;
    logic                lrq_full;
    logic                lrq_conf;
    logic [7:0]          lrq_oh;
    logic                wr_conf;
    logic                exp_miss;
    logic                exp_rd_conf;
    logic                exp_lrq_full;
    logic                exp_lrq_conf;
    logic [7:0]          exp_oh;
    logic                exp_wr;
    logic                exp_wr_conf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; rd_hit = 1'b0; rd_conf_i = 1'b0;
    lrq_full_i = 1'b0; lrq_conf_i = 1'b0; lrq_oh_i = '0; wr_conf_i = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] idx, input logic [PADDR_W-1:0] pa);
    req_valid = 1'b1; req_index = idx; req_paddr = pa;
    req_data = 64'hDEAD_BEEF_0000_0000 | 64'(idx); req_be = 8'hF0 | 8'(idx);
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] exp_data;
    exp_data = 64'hDEAD_BEEF_0000_0000 | 64'(v.idx);
    @(negedge clk);
    drive_req(v.idx, v.paddr);
    #1;
    check("v_accept", 64'(op_accept), 64'(1));
    check("v_op_index", 64'(op_index), 64'(v.idx));
    check("v_rd_valid", 64'(l1d_rd_valid), 64'(1));
    check("v_rd_paddr", 64'(l1d_rd_paddr), 64'(v.paddr));
    @(negedge clk);
    clear_inputs();
    rd_hit = v.hit; rd_conf_i = v.rd_conf;
    lrq_full_i = v.lrq_full; lrq_conf_i = v.lrq_conf; lrq_oh_i = v.lrq_oh;
    #1;
    check("v_resp_index", 64'(resp_index), 64'(v.idx));
    check("v_rd_miss", 64'(rd_miss), 64'(v.exp_miss));
    check("v_rd_conflict", 64'(rd_conflict), 64'(v.exp_rd_conf));
    check("v_lrq_req_valid", 64'(lrq_req_valid), 64'(v.exp_miss));
    check("v_lrq_paddr", 64'(lrq_req_paddr), v.exp_miss ? 64'(v.paddr) : 64'(0));
    check("v_lrq_full", 64'(lrq_full_o), 64'(v.exp_lrq_full));
    check("v_lrq_conflict", 64'(lrq_conflict_o), 64'(v.exp_lrq_conf));
    check("v_lrq_oh", 64'(lrq_index_oh_o), 64'(v.exp_oh));
    check("v_wr_valid", 64'(l1d_wr_valid), 64'(v.exp_wr));
    check("v_wr_paddr", 64'(l1d_wr_paddr), v.exp_wr ? 64'(v.paddr) : 64'(0));
    check("v_wr_data", l1d_wr_data, v.exp_wr ? exp_data : 64'(0));
    @(negedge clk);
    clear_inputs();
    wr_conf_i = v.wr_conf;
    #1;
    check("v_st1_idle", 64'(resp_index), 64'(0));
    check("v_wr_index", 64'(wr_index), v.exp_wr ? 64'(v.idx) : 64'(0));
    check("v_wr_conflict", 64'(wr_conflict_o), 64'(v.exp_wr_conf));
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    //          idx   paddr                 hit rdc  full lc  oh     wrc  miss rdc  full lc  oh     wr   wrc
    vecs[0] = '{4'd3,  56'h1000,             1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0};
    vecs[1] = '{4'd5,  56'h2000,             1'b0,1'b0,1'b0,1'b1,8'h04, 1'b0,1'b1,1'b0,1'b0,1'b1,8'h04, 1'b0,1'b0};
    vecs[2] = '{4'd2,  56'h3000,             1'b0,1'b0,1'b1,1'b0,8'h10, 1'b0,1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0};
    vecs[3] = '{4'd7,  56'h4000,             1'b1,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[4] = '{4'd9,  56'h5000,             1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1};
    vecs[5] = '{4'd15, 56'hFF_FFFF_FFFF_FFFF, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0};

    // Reset state with a request already pending on the input.
    req_valid = 1'b1; req_paddr = 56'h1000; rd_hit = 1'b1;
    #2;
    check("rst_accept", 64'(op_accept), 64'(0));
    check("rst_rd_valid", 64'(l1d_rd_valid), 64'(0));
    check("rst_wr_valid", 64'(l1d_wr_valid), 64'(0));
    repeat (2) @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back different lines: responses in order, one cycle apart.
    @(negedge clk); drive_req(4'd1, 56'h1000); #1;
    check("b2b_acc_a", 64'(op_accept), 64'(1));
    @(negedge clk); drive_req(4'd2, 56'h2040); rd_hit = 1'b1; #1;
    check("b2b_acc_b", 64'(op_accept), 64'(1));
    check("b2b_resp_a", 64'(resp_index), 64'(1));
    check("b2b_wr_paddr_a", 64'(l1d_wr_paddr), 64'h1000);
    @(negedge clk); req_valid = 1'b0; #1;
    check("b2b_resp_b", 64'(resp_index), 64'(2));
    check("b2b_wr_paddr_b", 64'(l1d_wr_paddr), 64'h2040);
    check("b2b_wr_index_a", 64'(wr_index), 64'(1));
    @(negedge clk); rd_hit = 1'b0; #1;
    check("b2b_wr_index_b", 64'(wr_index), 64'(2));
    check("b2b_st1_idle", 64'(resp_index), 64'(0));
    @(negedge clk); clear_inputs();

    // Same-line back-to-back.
    @(negedge clk); drive_req(4'd1, 56'h1000); #1;
    check("same_acc_a", 64'(op_accept), 64'(1));
    @(negedge clk); drive_req(4'd2, 56'h1008); rd_hit = 1'b1; #1;
`ifdef MSRH_STQ_COMMIT_HAZARD_EN
    check("haz_hold_1", 64'(op_accept), 64'(0));
    @(negedge clk); rd_hit = 1'b0; #1;
    check("haz_hold_2", 64'(op_accept), 64'(0));
    check("haz_wr_index_a", 64'(wr_index), 64'(1));
    @(negedge clk); #1;
    check("haz_acc_b", 64'(op_accept), 64'(1));
    @(negedge clk); req_valid = 1'b0; rd_hit = 1'b1; #1;
    check("haz_resp_b", 64'(resp_index), 64'(2));
    check("haz_wr_valid_b", 64'(l1d_wr_valid), 64'(1));
    @(negedge clk); clear_inputs();
`else
    check("nohaz_acc_b", 64'(op_accept), 64'(1));
    check("nohaz_wr_valid_a", 64'(l1d_wr_valid), 64'(1));
    @(negedge clk); req_valid = 1'b0; rd_hit = 1'b1; #1;
    check("nohaz_resp_b", 64'(resp_index), 64'(2));
    check("nohaz_rd_conflict", 64'(rd_conflict), 64'(1));
    check("nohaz_no_wr", 64'(l1d_wr_valid), 64'(0));
    check("nohaz_no_lrq", 64'(lrq_req_valid), 64'(0));
    check("nohaz_wr_index_a", 64'(wr_index), 64'(1));
    @(negedge clk); clear_inputs(); #1;
    check("nohaz_st2_idle", 64'(wr_index), 64'(0));
`endif
    @(negedge clk);

    // Reset with ST1 and ST2 occupied.
    @(negedge clk); drive_req(4'd4, 56'h6000);
    @(negedge clk); drive_req(4'd6, 56'h7000); rd_hit = 1'b1;
    @(negedge clk); drive_req(4'd8, 56'h8000); wr_conf_i = 1'b1; #1;
    check("pre_rst_wr_conflict", 64'(wr_conflict_o), 64'(1));
    rst_n = 1'b0; #1;
    check("arst_accept", 64'(op_accept), 64'(0));
    check("arst_rd_valid", 64'(l1d_rd_valid), 64'(0));
    check("arst_resp_index", 64'(resp_index), 64'(0));
    check("arst_wr_valid", 64'(l1d_wr_valid), 64'(0));
    check("arst_wr_index", 64'(wr_index), 64'(0));
    check("arst_wr_conflict", 64'(wr_conflict_o), 64'(0));
    @(negedge clk); req_valid = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("post_rst_wr_valid", 64'(l1d_wr_valid), 64'(0));
      check("post_rst_wr_conflict", 64'(wr_conflict_o), 64'(0));
      check("post_rst_resp", 64'(resp_index), 64'(0));
      @(negedge clk);
    end
    clear_inputs();

    // Fresh request after reset, write replay at T+2.
    drive_req(4'd10, 56'h9000); #1;
    check("post_rst_accept", 64'(op_accept), 64'(1));
    @(negedge clk); req_valid = 1'b0; rd_hit = 1'b1; #1;
    check("post_rst_wr_valid_hit", 64'(l1d_wr_valid), 64'(1));
    @(negedge clk); rd_hit = 1'b0; wr_conf_i = 1'b1; #1;
    check("post_rst_wr_index", 64'(wr_index), 64'(10));
    check("post_rst_wr_replay", 64'(wr_conflict_o), 64'(1));
    @(negedge clk); clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/msrh_stq_commit_resp.md
MSRH_STQ_COMMIT_RESP -- requirements
Module: msrh_stq_commit_resp

Interface
REQ-001 SHALL have parameter STQ_SIZE, 16, number of store queue entries; request index width is $clog2(STQ_SIZE).
REQ-002 SHALL have parameter PADDR_W, 56, physical address width.
REQ-003 SHALL have parameter DATA_W, 64, store data width; byte-enable width is DATA_W/8.
REQ-004 SHALL have parameter LINE_OFS_W, 6, cache-line offset bits ignored for line compare.
REQ-005 SHALL have parameter LRQ_SIZE, 8, LRQ entries (one-hot width).
REQ-006 SHALL use one clock and an asynchronous, active-low reset: i_clk in 1 clock; i_reset_n in 1 async active-low reset.
REQ-007 i_sq_req_valid in 1, committed store request; i_sq_req_index in log2(STQ_SIZE), requesting entry; i_sq_req_paddr in PADDR_W; i_sq_req_data in DATA_W; i_sq_req_be in DATA_W/8.
REQ-008 o_sq_op_accept out 1, request taken this cycle; o_sq_op_index out log2(STQ_SIZE), echo of accepted index.
REQ-009 o_sq_resp_index out log2(STQ_SIZE); o_sq_l1d_rd_miss out 1; o_sq_l1d_rd_conflict out 1; o_sq_lrq_full out 1; o_sq_lrq_conflict out 1; o_sq_lrq_index_oh out LRQ_SIZE.
REQ-010 o_sq_wr_index out log2(STQ_SIZE); o_sq_l1d_wr_conflict out 1, write replay.
REQ-011 o_l1d_rd_valid out 1; o_l1d_rd_paddr out PADDR_W; i_l1d_rd_hit in 1; i_l1d_rd_conflict in 1 (both valid the cycle after o_l1d_rd_valid).
REQ-012 o_lrq_req_valid out 1; o_lrq_req_paddr out PADDR_W; i_lrq_full in 1; i_lrq_conflict in 1; i_lrq_index_oh in LRQ_SIZE (all combinational, same cycle as o_lrq_req_valid).
REQ-013 o_l1d_wr_valid out 1; o_l1d_wr_paddr out PADDR_W; o_l1d_wr_data out DATA_W; o_l1d_wr_be out DATA_W/8; i_l1d_wr_conflict in 1 (valid the cycle after o_l1d_wr_valid).

Function
REQ-014 SHALL be a 3-stage pipeline ST0 (accept/read issue), ST1 (read check/LRQ), ST2 (write result), one request per cycle.
REQ-015 ST0: o_sq_op_accept = i_sq_req_valid & !hazard; on accept, o_l1d_rd_valid=1 with request paddr and ST1 loaded with index/paddr/data/be.
REQ-016 ST1 (accept cycle +1): exactly one of these SHALL hold: i_l1d_rd_conflict -> o_sq_l1d_rd_conflict=1; else !i_l1d_rd_hit -> o_sq_l1d_rd_miss=1, o_lrq_req_valid=1; else hit -> o_l1d_wr_valid=1, ST2 loaded.
REQ-017 rd_conflict SHALL take priority over miss; on conflict no LRQ request and no write are issued.
REQ-018 On miss, o_sq_lrq_conflict=i_lrq_conflict, o_sq_lrq_index_oh=i_lrq_index_oh when conflict, else all zero; o_sq_lrq_full=i_lrq_full with index_oh zero.
REQ-019 ST1 response outputs SHALL be zero when ST1 invalid; o_sq_resp_index SHALL equal ST1 index when valid.
REQ-020 ST2 (accept cycle +2): o_sq_l1d_wr_conflict=i_l1d_wr_conflict, o_sq_wr_index=ST2 index; no conflict means write complete.
REQ-021 Hazard: request line (paddr[PADDR_W-1:LINE_OFS_W]) equals valid ST1 or ST2 line.
REQ-022 Committed-store flushes SHALL NOT affect in-flight stages.
REQ-023 Back-to-back accepts of different lines SHALL each receive responses in order, one cycle apart.

Reset
REQ-024 On i_reset_n low all stage valids and every output SHALL be zero asynchronously; in-flight requests are discarded, no response produced after release.
REQ-025 First accept SHALL be possible the first cycle after reset release.

Configuration
REQ-026 Macro MSRH_STQ_COMMIT_HAZARD_EN: defined -> hazard blocks accept (REQ-021); undefined -> hazard never blocks, a same-line request reaching ST1 while ST2 valid on same line SHALL report o_sq_l1d_rd_conflict=1 regardless of L1D response.

Verification
REQ-027 Accept idx 3, paddr 0x1000, hit next cycle, no wr conflict -> accept T, no ST1 flags T+1, o_l1d_wr_valid T+1, o_sq_wr_index=3 conflict 0 T+2.
REQ-028 idx 5 miss, i_lrq_conflict=1, index_oh 0x04 -> T+1 rd_miss=1, lrq_conflict=1, lrq_index_oh=0x04, no write.
REQ-029 idx 2 miss, i_lrq_full=1 -> rd_miss=1, lrq_full=1, index_oh=0x00; rd hit+rd_conflict together -> only rd_conflict=1.
REQ-030 Two back-to-back requests line 0x1000 (HAZARD_EN) -> second accept held 2 cycles; different lines -> both accepted consecutively.
REQ-031 Reset asserted with ST1/ST2 valid -> all outputs 0 immediately, no responses after release; wr_conflict=1 at T+2 -> o_sq_l1d_wr_conflict=1.
